// File: rtl/seq_detector_param.sv
// seq_detector_param
//   Moore serial pattern detector. Each qualified clock (en=1) shifts w into a
//   PAT_W-bit history. Once the history is full, it is compared against two
//   runtime-programmable patterns. Both patterns share one don't-care mask.
//   The block raises a registered match flag, per-pattern hit bits and a
//   saturating match counter.
//
// Parameters
//   PAT_W      pattern length in bits (2..16)
//   CNT_W      match counter width
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous reset, active low
//   en         sample qualifier
//   w          serial data bit
//   clr        synchronous clear of history, state, z, hit and count
//   overlap    1 = overlapping detection, 0 = restart history after a match
//   pat_a      pattern A (bit PAT_W-1 = oldest sample, bit 0 = newest)
//   pat_b      pattern B (same ordering as pat_a)
//   mask       per-position compare enable, shared by A and B (0 = don't care)
//   z          Moore match flag
//   hit        {B,A} match bits for the current state
//   match_cnt  number of accepted matches, saturating
module seq_detector_param #(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             w,
    input  logic             clr,
    input  logic             overlap,
    input  logic [PAT_W-1:0] pat_a,
    input  logic [PAT_W-1:0] pat_b,
    input  logic [PAT_W-1:0] mask,
    output logic             z,
    output logic [1:0]       hit,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_W);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        ARMED   = 2'd2,
        MATCH   = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [1:0]       hit_q, hit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Candidate history/fill for an accepted sample, before the compare.
    logic [PAT_W-1:0] hist_nx;
    logic [FW-1:0]    fill_nx;
    logic             full_nx;
    logic [1:0]       cmp_nx;

    always_comb begin
        // In non-overlapping mode, the sample after a match starts a new window.
        if (state_q == MATCH && !overlap) begin
            hist_nx = {{(PAT_W-1){1'b0}}, w};
            fill_nx = FW'(1);
        end else begin
            hist_nx = {hist_q[PAT_W-2:0], w};
            fill_nx = (fill_q == FULL) ? FULL : fill_q + FW'(1);
        end
        full_nx   = (fill_nx == FULL);
        cmp_nx[0] = full_nx && (((hist_nx ^ pat_a) & mask) == '0);
        cmp_nx[1] = full_nx && (((hist_nx ^ pat_b) & mask) == '0);
    end

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        hit_d   = hit_q;
        cnt_d   = cnt_q;

        if (clr) begin
            state_d = EMPTY;
            hist_d  = '0;
            fill_d  = '0;
            hit_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                EMPTY, FILLING, ARMED, MATCH: begin
                    if (en) begin
                        hist_d = hist_nx;
                        fill_d = fill_nx;
                        hit_d  = cmp_nx;
                        if (!full_nx)
                            state_d = FILLING;
                        else if (|cmp_nx)
                            state_d = MATCH;
                        else
                            state_d = ARMED;
                        // One count per accepted matching sample, even when
                        // both patterns hit.
                        if (full_nx && (|cmp_nx) && (cnt_q != '1))
                            cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    // An unknown encoding recovers to a clean, empty window.
                    state_d = EMPTY;
                    hist_d  = '0;
                    fill_d  = '0;
                    hit_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            hist_q  <= '0;
            fill_q  <= '0;
            hit_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            hit_q   <= hit_d;
            cnt_q   <= cnt_d;
        end
    end

    assign z         = (state_q == MATCH);
    assign hit       = hit_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       w = 1'b0;
    logic       clr = 1'b0;
    logic       overlap = 1'b1;
    logic [2:0] pat_a = 3'b110;
    logic [2:0] pat_b = 3'b101;
    logic [2:0] mask = 3'b111;

    logic       z, z_s;
    logic [1:0] hit, hit_s;
    logic [7:0] match_cnt;
    logic [1:0] cnt_s;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_detector_param #(.PAT_W(3), .CNT_W(8)) u_dut (
        .clk(clk), .reset(reset), .en(en), .w(w), .clr(clr), .overlap(overlap),
        .pat_a(pat_a), .pat_b(pat_b), .mask(mask),
        .z(z), .hit(hit), .match_cnt(match_cnt)
    );

    // Narrow-counter instance for the saturation check.
    seq_detector_param #(.PAT_W(3), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .en(en), .w(w), .clr(clr), .overlap(overlap),
        .pat_a(pat_a), .pat_b(pat_b), .mask(mask),
        .z(z_s), .hit(hit_s), .match_cnt(cnt_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input logic b);
        w  = b;
        en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic chk3(input string tag, input logic ez, input logic [1:0] eh, input logic [7:0] ec);
        chk({tag, ".z"},   32'(z),         32'(ez));
        chk({tag, ".hit"}, 32'(hit),       32'(eh));
        chk({tag, ".cnt"}, 32'(match_cnt), 32'(ec));
    endtask

    initial begin
        // Reset state while reset is held low.
        repeat (2) @(posedge clk);
        #1;
        chk3("rst", 1'b0, 2'b00, 8'd0);
        chk("rst.cnt_s", 32'(cnt_s), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // 1: overlapping, stream 1,1,0,1
        sample(1); chk3("t1.s1", 1'b0, 2'b00, 8'd0);
        sample(1); chk3("t1.s2", 1'b0, 2'b00, 8'd0);
        sample(0); chk3("t1.s3", 1'b1, 2'b01, 8'd1);
        sample(1); chk3("t1.s4", 1'b1, 2'b10, 8'd2);

        // 2a: overlap=1, stream 1,0,1,0,1
        do_clr(); chk3("t2a.clr", 1'b0, 2'b00, 8'd0);
        sample(1); sample(0);
        sample(1); chk3("t2a.s3", 1'b1, 2'b10, 8'd1);
        sample(0); chk3("t2a.s4", 1'b0, 2'b00, 8'd1);
        sample(1); chk3("t2a.s5", 1'b1, 2'b10, 8'd2);

        // 2b: overlap=0, history restarts after a match
        overlap = 1'b0;
        do_clr();
        sample(1); sample(0);
        sample(1); chk3("t2b.s3", 1'b1, 2'b10, 8'd1);
        sample(0); chk3("t2b.s4", 1'b0, 2'b00, 8'd1);
        sample(1); chk3("t2b.s5", 1'b0, 2'b00, 8'd1);
        overlap = 1'b1;

        // 3: en=0 gap between samples 2 and 3
        do_clr();
        sample(1); sample(1);
        w = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk3("t3.gap", 1'b0, 2'b00, 8'd0);
        end
        sample(0); chk3("t3.s3", 1'b1, 2'b01, 8'd1);

        // 4: masked compare, middle bit don't care
        mask  = 3'b101;
        pat_a = 3'b100;
        pat_b = 3'b011;
        do_clr();
        sample(1); sample(0); sample(0);
        chk("t4.100.z", 32'(z), 32'd1);   chk("t4.100.hit", 32'(hit), 32'b01);
        do_clr();
        sample(1); sample(1); sample(0);
        chk("t4.110.z", 32'(z), 32'd1);   chk("t4.110.hit", 32'(hit), 32'b01);
        do_clr();
        sample(0); sample(1); sample(0);
        chk("t4.010.z", 32'(z), 32'd0);   chk("t4.010.hit", 32'(hit), 32'b00);

        // 5: mask=0, counter saturation on the 2-bit instance
        mask = 3'b000;
        do_clr();
        for (int i = 1; i <= 10; i++) begin
            sample(i[0]);
            chk("t5.cnt_s", 32'(cnt_s), (i < 3) ? 32'd0 : ((i - 2 > 3) ? 32'd3 : 32'(i - 2)));
            chk("t5.z_s", 32'(z_s), (i >= 3) ? 32'd1 : 32'd0);
        end
        chk("t5.cnt8", 32'(match_cnt), 32'd8);

        // 6a: asynchronous reset pulse mid-cycle
        #3 reset = 1'b0;
        #1;
        chk3("t6a.async", 1'b0, 2'b00, 8'd0);
        chk("t6a.cnt_s", 32'(cnt_s), 32'd0);
        #2 reset = 1'b1;
        @(posedge clk); #1;
        sample(1); chk("t6a.s1.z", 32'(z), 32'd0);
        sample(1); chk("t6a.s2.z", 32'(z), 32'd0);
        sample(1); chk3("t6a.s3", 1'b1, 2'b11, 8'd1);

        // 6b: clr with en=1; the sample in that cycle is dropped
        clr = 1'b1; en = 1'b1; w = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; en = 1'b0;
        chk3("t6b.clr", 1'b0, 2'b00, 8'd0);
        sample(1); chk("t6b.s1.z", 32'(z), 32'd0);
        sample(1); chk("t6b.s2.z", 32'(z), 32'd0);
        sample(1); chk3("t6b.s3", 1'b1, 2'b11, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
